// File: rtl/checker_pkg.sv
// Shared types and helpers for the checkers board input path.
// Cell encoding, legal-move slot layout, FSM states, cursor step.
// Build option: CURSOR_WRAP_EN makes the cursor wrap instead of saturate.
package checker_pkg;

   localparam int LOC_W   = 6;
   localparam int OCC     = 2;
   localparam int RED     = 1;
   localparam int KING    = 0;
   localparam int SLOT_W  = 7;
   localparam int SLOT_N  = 4;
   localparam int BOARD_W = 192;

   typedef enum logic [1:0] {
      BROWSE,
      PICKED,
      COMMIT
   } state_t;

   // True when the square holds a piece of the side to move.
   function automatic logic own_piece(
      input logic [BOARD_W-1:0] board,
      input logic [LOC_W-1:0]   loc,
      input logic               red_turn
   );
      int base;
      base = 3 * int'(loc);
      return board[base + OCC] &&
             (board[base + RED] == red_turn);
   endfunction

   // One step along an axis; inc = 1 steps up, 0 steps down.
   function automatic logic [2:0] step(
      input logic [2:0] c,
      input logic       inc
   );
`ifdef CURSOR_WRAP_EN
      return inc ? c + 3'd1 : c - 3'd1;
`else
      if (inc)
         return (c == 3'd7) ? c : c + 3'd1;
      else
         return (c == 3'd0) ? c : c - 3'd1;
`endif
   endfunction

endpackage

// File: rtl/btn_edge_repeat.sv
// Rising-edge detector with optional hold-to-repeat for one button.
// Ports: clk, rst, level (debounced), evt (registered one-cycle event).
module btn_edge_repeat #(
   parameter int REPEAT_CYCLES = 12_500_000,
   parameter bit REPEAT_EN     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic evt
);

   localparam int CW = $clog2(REPEAT_CYCLES + 1);

   logic          prev;
   logic [CW-1:0] cnt;
   logic          rise;
   logic          rep;

   assign rise = level && !prev;
   // Counter measures held cycles since the last event; it fires once
   // REPEAT_CYCLES full cycles have elapsed, then starts over.
   assign rep  = REPEAT_EN && level && prev &&
                 (cnt == CW'(REPEAT_CYCLES));

   always_ff @(posedge clk) begin
      if (rst) begin
         prev <= 1'b0;
         cnt  <= '0;
         evt  <= 1'b0;
      end else begin
         prev <= level;
         evt  <= rise || rep;
         if (!REPEAT_EN || !level || rise || rep)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/board_cursor_ctrl.sv
// Cursor / selection / move-request controller for the checkers board.
// In: clk, rst, btn_*, serialized_board, turn_red, legal_move,
// frame_start, move_ready. Out: move_valid/from/to, cursor_loc,
// select_loc, select_valid (display outputs frame-synced).
// Build option: CURSOR_WRAP_EN (cursor wraps at board edges).
module board_cursor_ctrl
   import checker_pkg::*;
#(
   parameter int          REPEAT_CYCLES = 12_500_000,
   parameter logic [5:0]  INIT_CURSOR   = 6'd0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      btn_up,
   input  logic                      btn_down,
   input  logic                      btn_left,
   input  logic                      btn_right,
   input  logic                      btn_sel,
   input  logic [BOARD_W-1:0]        serialized_board,
   input  logic                      turn_red,
   input  logic [SLOT_W*SLOT_N-1:0]  legal_move,
   input  logic                      frame_start,
   input  logic                      move_ready,
   output logic                      move_valid,
   output logic [LOC_W-1:0]          move_from,
   output logic [LOC_W-1:0]          move_to,
   output logic [LOC_W-1:0]          cursor_loc,
   output logic [LOC_W-1:0]          select_loc,
   output logic                      select_valid
);

   logic ev_up, ev_down, ev_left, ev_right, ev_sel;

   btn_edge_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
      .clk(clk), .rst(rst), .level(btn_up), .evt(ev_up));
   btn_edge_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_down (
      .clk(clk), .rst(rst), .level(btn_down), .evt(ev_down));
   btn_edge_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_left (
      .clk(clk), .rst(rst), .level(btn_left), .evt(ev_left));
   btn_edge_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_right (
      .clk(clk), .rst(rst), .level(btn_right), .evt(ev_right));
   btn_edge_repeat #(
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN(1'b0)
   ) u_sel (
      .clk(clk), .rst(rst), .level(btn_sel), .evt(ev_sel));

   state_t           state;
   logic [LOC_W-1:0] cur;
   logic [LOC_W-1:0] sel_loc;
   logic             sel_valid;
   logic [LOC_W-1:0] next_cur;
   logic             own_cur;
   logic             legal_hit;

   assign own_cur = own_piece(serialized_board, cur, turn_red);

   always_comb begin
      legal_hit = 1'b0;
      for (int s = 0; s < SLOT_N; s++) begin
         if (legal_move[s*SLOT_W + 6] &&
             legal_move[s*SLOT_W +: LOC_W] == cur)
            legal_hit = 1'b1;
      end
   end

   // Only one direction is applied per cycle: up > down > left > right.
   always_comb begin
      next_cur = cur;
      priority case (1'b1)
         ev_up:    next_cur[2:0] = step(cur[2:0], 1'b1);
         ev_down:  next_cur[2:0] = step(cur[2:0], 1'b0);
         ev_left:  next_cur[5:3] = step(cur[5:3], 1'b0);
         ev_right: next_cur[5:3] = step(cur[5:3], 1'b1);
         default:  next_cur = cur;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= BROWSE;
         cur          <= INIT_CURSOR;
         sel_loc      <= '0;
         sel_valid    <= 1'b0;
         move_valid   <= 1'b0;
         move_from    <= '0;
         move_to      <= '0;
         cursor_loc   <= INIT_CURSOR;
         select_loc   <= '0;
         select_valid <= 1'b0;
      end else begin
         // Display copies pre-update values, so same-cycle changes
         // wait for the next frame.
         if (frame_start) begin
            cursor_loc   <= cur;
            select_loc   <= sel_loc;
            select_valid <= sel_valid;
         end

         // Select is judged on the cursor before this cycle's move.
         unique case (state)
            BROWSE: begin
               if (ev_sel && own_cur) begin
                  sel_loc   <= cur;
                  sel_valid <= 1'b1;
                  state     <= PICKED;
               end
            end
            PICKED: begin
               if (ev_sel) begin
                  if (cur == sel_loc) begin
                     sel_valid <= 1'b0;
                     state     <= BROWSE;
                  end else if (own_cur) begin
                     sel_loc <= cur;
                  end else if (legal_hit) begin
                     move_from  <= sel_loc;
                     move_to    <= cur;
                     move_valid <= 1'b1;
                     state      <= COMMIT;
                  end
               end
            end
            COMMIT: begin
               if (move_valid && move_ready) begin
                  move_valid <= 1'b0;
                  sel_valid  <= 1'b0;
                  state      <= BROWSE;
               end
            end
            default: state <= BROWSE;
         endcase

         if (state != COMMIT)
            cur <= next_cur;
      end
   end

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Directed self-checking bench for board_cursor_ctrl.
// Uses REPEAT_CYCLES = 4; honours CURSOR_WRAP_EN for expectations.
module tb_board_cursor_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         btn_up, btn_down, btn_left, btn_right, btn_sel;
   logic [191:0] serialized_board;
   logic         turn_red;
   logic [27:0]  legal_move;
   logic         frame_start;
   logic         move_ready;
   logic         move_valid;
   logic [5:0]   move_from, move_to;
   logic [5:0]   cursor_loc, select_loc;
   logic         select_valid;

   int tests = 0;
   int fails = 0;

   board_cursor_ctrl #(
      .REPEAT_CYCLES(4),
      .INIT_CURSOR(6'd0)
   ) dut (
      .clk(clk), .rst(rst),
      .btn_up(btn_up), .btn_down(btn_down),
      .btn_left(btn_left), .btn_right(btn_right),
      .btn_sel(btn_sel),
      .serialized_board(serialized_board),
      .turn_red(turn_red), .legal_move(legal_move),
      .frame_start(frame_start), .move_ready(move_ready),
      .move_valid(move_valid),
      .move_from(move_from), .move_to(move_to),
      .cursor_loc(cursor_loc), .select_loc(select_loc),
      .select_valid(select_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   // m = {up, down, left, right, sel}
   task automatic press(input logic [4:0] m);
      {btn_up, btn_down, btn_left, btn_right, btn_sel} = m;
      tick();
      {btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
      tick();
      tick();
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   localparam logic [4:0] UP = 5'b10000;
   localparam logic [4:0] DN = 5'b01000;
   localparam logic [4:0] LF = 5'b00100;
   localparam logic [4:0] RT = 5'b00010;
   localparam logic [4:0] SL = 5'b00001;

   initial begin
      {btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
      frame_start = 1'b0;
      move_ready  = 1'b0;
      turn_red    = 1'b1;
      serialized_board = '0;
      serialized_board[27 +: 3] = 3'b110;
      serialized_board[6 +: 3]  = 3'b110;
      serialized_board[81 +: 3] = 3'b100;
      legal_move = {21'd0, 1'b1, 6'd18};
      rst = 1'b0;

      // Reset state
      do_reset();
      chk("rst_cursor", 32'(cursor_loc), 32'd0);
      chk("rst_sel_valid", 32'(select_valid), 32'd0);
      chk("rst_sel_loc", 32'(select_loc), 32'd0);
      chk("rst_mv", 32'(move_valid), 32'd0);
      chk("rst_from", 32'(move_from), 32'd0);
      chk("rst_to", 32'(move_to), 32'd0);

      // Basic movement, display frozen until frame_start
      press(UP); press(UP); press(UP);
      press(RT); press(RT);
      chk("no_frame_yet", 32'(cursor_loc), 32'd0);
      frame();
      chk("move_19", 32'(cursor_loc), 32'd19);

      // Board-edge behaviour at (0,0)
      do_reset();
      press(LF);
      frame();
`ifdef CURSOR_WRAP_EN
      chk("left_edge", 32'(cursor_loc), 32'd56);
`else
      chk("left_edge", 32'(cursor_loc), 32'd0);
`endif
      press(DN);
      frame();
`ifdef CURSOR_WRAP_EN
      chk("down_edge", 32'(cursor_loc), 32'd63);
`else
      chk("down_edge", 32'(cursor_loc), 32'd0);
`endif

      // Select, deselect, reselect
      do_reset();
      press(RT); press(UP);
      press(SL);
      chk("sel_frozen", 32'(select_valid), 32'd0);
      frame();
      chk("sel_valid", 32'(select_valid), 32'd1);
      chk("sel_loc9", 32'(select_loc), 32'd9);
      press(SL);
      frame();
      chk("desel", 32'(select_valid), 32'd0);
      press(SL);
      press(LF); press(UP);
      press(SL);
      frame();
      chk("resel_2", 32'(select_loc), 32'd2);
      chk("resel_v", 32'(select_valid), 32'd1);
      press(RT); press(DN);
      press(SL);
      frame();
      chk("resel_9", 32'(select_loc), 32'd9);

      // Commit and handshake
      press(RT); press(UP);
      press(SL);
      chk("mv_set", 32'(move_valid), 32'd1);
      chk("mv_from", 32'(move_from), 32'd9);
      chk("mv_to", 32'(move_to), 32'd18);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_mv", 32'(move_valid), 32'd1);
         chk("hold_to", 32'(move_to), 32'd18);
      end
      press(UP);
      chk("drop_evt_mv", 32'(move_valid), 32'd1);
      move_ready = 1'b1;
      tick();
      move_ready = 1'b0;
      chk("hs_done", 32'(move_valid), 32'd0);
      frame();
      chk("post_cursor", 32'(cursor_loc), 32'd18);
      chk("post_sel", 32'(select_valid), 32'd0);

      // Auto-repeat: edge plus two repeats in 13 held cycles
      do_reset();
      btn_up = 1'b1;
      for (int i = 0; i < 13; i++) tick();
      btn_up = 1'b0;
      tick(); tick();
      frame();
      chk("repeat_y3", 32'(cursor_loc), 32'd3);
      press(UP | LF);
      frame();
      chk("prio_up", 32'(cursor_loc), 32'd4);

      // Reset during COMMIT
      do_reset();
      press(RT); press(UP); press(SL);
      press(RT); press(UP); press(SL);
      frame();
      chk("pre_rst_mv", 32'(move_valid), 32'd1);
      chk("pre_rst_cur", 32'(cursor_loc), 32'd18);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_commit_mv", 32'(move_valid), 32'd0);
      chk("rst_commit_cur", 32'(cursor_loc), 32'd0);
      press(RT); press(UP); press(SL);
      frame();
      chk("browse_after", 32'(select_valid), 32'd1);
      chk("browse_loc", 32'(select_loc), 32'd9);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
